// File: rtl/sample_framer_pkg.sv
// Shared types and header layout for the sample framer.
// The header word carries magic, drop flag, sequence number and frame length.
package sample_framer_pkg;

  localparam logic [7:0] HDR_MAGIC      = 8'hA5;
  localparam int         HDR_MAGIC_LSB  = 24;
  localparam int         HDR_DROP_BIT   = 23;
  localparam int         HDR_SEQ_LSB    = 8;
  localparam int         HDR_LEN_LSB    = 0;

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} framer_state_t;

  function automatic logic [31:0] make_header(input logic       drop,
                                              input logic [7:0] seq,
                                              input logic [7:0] len);
    logic [31:0] h;
    h = '0;
    h[HDR_MAGIC_LSB +: 8] = HDR_MAGIC;
    h[HDR_DROP_BIT]       = drop;
    h[HDR_SEQ_LSB +: 8]   = seq;
    h[HDR_LEN_LSB +: 8]   = len;
    return h;
  endfunction

endpackage

// File: rtl/sample_framer_fifo.sv
// Single-clock show-ahead FIFO: the head entry is always visible on dout.
// Fullness is judged before any same-cycle pop, so a push into a full FIFO is refused.
module sync_fifo #(
  parameter int DW         = 24,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic [DW-1:0]                 din,
  input  logic                          pop,
  output logic [DW-1:0]                 dout,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int              AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]     DEPTH_L = (AW+1)'(FIFO_DEPTH);

  logic [DW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == DEPTH_L);
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/sample_framer.sv
// Packs decimated samples into AXI-stream frames: one header word, then FRAME_LEN
// sign-extended sample words. Samples arriving while the FIFO is full are dropped and flagged.
module sample_framer
  import sample_framer_pkg::*;
#(
  parameter  int DW         = 24,
  parameter  int FRAME_LEN  = 16,
  parameter  int FIFO_DEPTH = 64,
  localparam int AW         = $clog2(FIFO_DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          valid_i,
  input  logic [DW-1:0] data_i,
  input  logic          clear_i,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [31:0]   m_data,
  output logic          m_last,
  output logic          overflow,
  output logic [AW:0]   fifo_level
);

  localparam logic [AW:0] LEN_LVL  = (AW+1)'(FRAME_LEN);
  localparam logic [7:0]  LEN_BYTE = 8'(FRAME_LEN);
  localparam logic [7:0]  LAST_CNT = 8'(FRAME_LEN - 1);

  framer_state_t state;
  logic [7:0]    seq;
  logic [7:0]    beat_cnt;
  logic          drop_flag;
  logic          drop;
  logic          full;
  logic          empty;
  logic          pop;
  logic          hdr_load;
  logic [DW-1:0] head;
  logic [31:0]   head_ext;

  sync_fifo #(.DW(DW), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (valid_i),
    .din   (data_i),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  assign drop     = valid_i && full;
  assign head_ext = 32'($signed(head));
  assign hdr_load = (state == IDLE) && (fifo_level >= LEN_LVL);

  // A pop accompanies every payload load into the output register.
  always_comb begin
    pop = 1'b0;
    if (m_ready && !empty) begin
      if (state == HEADER)                 pop = 1'b1;
      if (state == PAYLOAD && !m_last)     pop = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      drop_flag <= 1'b0;
    end else begin
      if (drop)         overflow <= 1'b1;
      else if (clear_i) overflow <= 1'b0;
      if (hdr_load)     drop_flag <= drop;
      else if (drop)    drop_flag <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      m_valid  <= 1'b0;
      m_last   <= 1'b0;
      m_data   <= '0;
      seq      <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hdr_load) begin
            state   <= HEADER;
            m_valid <= 1'b1;
            m_last  <= 1'b0;
            m_data  <= make_header(drop_flag, seq, LEN_BYTE);
          end
        end
        HEADER: begin
          if (m_ready) begin
            state    <= PAYLOAD;
            m_data   <= head_ext;
            m_last   <= (FRAME_LEN == 1);
            beat_cnt <= 8'd1;
          end
        end
        PAYLOAD: begin
          if (m_ready) begin
            if (m_last) begin
              state   <= IDLE;
              m_valid <= 1'b0;
              m_last  <= 1'b0;
              seq     <= seq + 8'd1;
            end else begin
              m_data   <= head_ext;
              beat_cnt <= beat_cnt + 8'd1;
              m_last   <= (beat_cnt == LAST_CNT);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
